// File: rtl/spi_sample_averager_pkg.sv
// Shared types and helpers for the SPI sample averager: FSM state encoding
// and counter sizing.
package spi_sample_averager_pkg;

    localparam int SPI_WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_sample_averager_if.sv
// Read handshake between the SPI reader (slave) and its consumer (master):
// rd request out, d_ready/d back from the SCLK domain.
interface spi_sample_averager_if;
    import spi_sample_averager_pkg::*;

    logic                  rd;
    logic                  d_ready;
    logic [SPI_WORD_W-1:0] d;

    modport master (output rd, input d_ready, input d);
    modport slave  (input rd, output d_ready, output d);

endinterface

// File: rtl/spi_sample_averager_sync_2ff.sv
// Single-bit two-flop synchronizer for signals arriving from the SCLK domain;
// both stages clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments keep the two stages a real shift chain;
    // blocking ones would collapse them into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_sample_averager.sv
// Periodically reads a 16-bit word over the rd/d_ready/d handshake, extracts a
// bit field and produces a block average over 2^LOG2_AVG captured fields.
module spi_sample_averager
    import spi_sample_averager_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int TIMEOUT       = 100000,
    parameter int FIELD_LSB     = 4,
    parameter int FIELD_W       = 8,
    parameter int LOG2_AVG      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    spi_sample_averager_if.master  bus,
    output logic [FIELD_W-1:0]     o_sample,
    output logic                   o_sample_valid,
    output logic [FIELD_W-1:0]     o_avg,
    output logic                   o_avg_valid,
    output logic                   o_timeout_err,
    output logic                   o_busy
);

    localparam int PER_W = cnt_width(SAMPLE_PERIOD);
    localparam int TO_W  = cnt_width(TIMEOUT);
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int ACC_W = FIELD_W + LOG2_AVG;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

    state_t             r_state;
    logic [PER_W-1:0]   r_per_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rd;
    logic [FIELD_W-1:0] r_sample;
    logic               r_sample_valid;
    logic [FIELD_W-1:0] r_avg;
    logic               r_avg_valid;
    logic               r_timeout_err;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [PER_W-1:0]   w_per_cnt_nxt;
    logic [TO_W-1:0]    w_to_cnt_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_rd_nxt;
    logic [FIELD_W-1:0] w_sample_nxt;
    logic               w_sample_valid_nxt;
    logic [FIELD_W-1:0] w_avg_nxt;
    logic               w_avg_valid_nxt;
    logic               w_timeout_err_nxt;
    logic               w_busy_nxt;

    logic               w_d_ready_s;
    logic [FIELD_W-1:0] w_field;
    logic [ACC_W-1:0]   w_sum;

    sync_2ff u_sync_d_ready (
        .clk (clk),
        .rst (rst),
        .i_d (bus.d_ready),
        .o_q (w_d_ready_s)
    );

    assign w_field    = FIELD_W'(bus.d >> FIELD_LSB);
    assign w_sum      = r_acc + ACC_W'(w_field);
    assign w_busy_nxt = (w_state_nxt != ST_IDLE);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt        = r_state;
        w_per_cnt_nxt      = r_per_cnt;
        w_to_cnt_nxt       = r_to_cnt;
        w_acc_nxt          = r_acc;
        w_cnt_nxt          = r_cnt;
        w_rd_nxt           = 1'b0;
        w_sample_nxt       = r_sample;
        w_sample_valid_nxt = 1'b0;
        w_avg_nxt          = r_avg;
        w_avg_valid_nxt    = 1'b0;
        w_timeout_err_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!i_en) begin
                    w_per_cnt_nxt = '0;
                end else if (r_per_cnt == PER_LAST) begin
                    w_per_cnt_nxt = '0;
                    w_to_cnt_nxt  = '0;
                    w_rd_nxt      = 1'b1;
                    w_state_nxt   = ST_REQ;
                end else begin
                    w_per_cnt_nxt = r_per_cnt + PER_W'(1);
                end
            end

            ST_REQ: begin
                // Accumulate on the capture edge itself so avg_valid lines up
                // with the sample_valid of the last sample in the block.
                if (w_d_ready_s) begin
                    w_sample_nxt       = w_field;
                    w_sample_valid_nxt = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_avg_nxt       = FIELD_W'(w_sum >> LOG2_AVG);
                        w_avg_valid_nxt = 1'b1;
                        w_acc_nxt       = '0;
                        w_cnt_nxt       = '0;
                    end else begin
                        w_acc_nxt = w_sum;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    w_state_nxt = ST_CAPTURE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = ST_RELEASE;
                end else begin
                    w_rd_nxt     = 1'b1;
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end

            ST_CAPTURE: begin
                w_state_nxt = ST_RELEASE;
            end

            ST_RELEASE: begin
                if (!w_d_ready_s) begin
                    w_per_cnt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_per_cnt      <= '0;
            r_to_cnt       <= '0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_rd           <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_avg          <= '0;
            r_avg_valid    <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_per_cnt      <= w_per_cnt_nxt;
            r_to_cnt       <= w_to_cnt_nxt;
            r_acc          <= w_acc_nxt;
            r_cnt          <= w_cnt_nxt;
            r_rd           <= w_rd_nxt;
            r_sample       <= w_sample_nxt;
            r_sample_valid <= w_sample_valid_nxt;
            r_avg          <= w_avg_nxt;
            r_avg_valid    <= w_avg_valid_nxt;
            r_timeout_err  <= w_timeout_err_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    assign bus.rd         = r_rd;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_sample_valid;
    assign o_avg          = r_avg;
    assign o_avg_valid    = r_avg_valid;
    assign o_timeout_err  = r_timeout_err;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_spi_sample_averager.sv
// Directed-plus-random bench for spi_sample_averager: an SPI reader model
// answers rd requests, and a block-average reference model predicts outputs.
module tb_spi_sample_averager;

    localparam int SP = 4;
    localparam int TO = 64;
    localparam int L2 = 2;
    localparam int FL = 4;
    localparam int FW = 8;
    localparam int N  = 1 << L2;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_HOLD   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [FW-1:0] sample;
    logic          sample_valid;
    logic [FW-1:0] avg;
    logic          avg_valid;
    logic          timeout_err;
    logic          busy;

    spi_sample_averager_if bus ();

    spi_sample_averager #(
        .SAMPLE_PERIOD (SP),
        .TIMEOUT       (TO),
        .FIELD_LSB     (FL),
        .FIELD_W       (FW),
        .LOG2_AVG      (L2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_en           (en),
        .bus            (bus),
        .o_sample       (sample),
        .o_sample_valid (sample_valid),
        .o_avg          (avg),
        .o_avg_valid    (avg_valid),
        .o_timeout_err  (timeout_err),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    int          mode = M_NORMAL;
    logic [15:0] next_word = '0;
    int          last_dr_fall = 0;
    int          last_rd_rise = 0;
    int          rel = 0;
    int          blk[$];

    // SPI reader model: d_ready rises 20 cycles after rd rises and falls a
    // hold time after rd falls.
    initial begin
        int hold;
        bus.d_ready = 1'b0;
        bus.d       = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.rd === 1'b1 && mode != M_NEVER) begin
                hold = (mode == M_HOLD) ? 30 : 10;
                repeat (20) @(posedge clk);
                #1;
                bus.d       = next_word;
                bus.d_ready = 1'b1;
                while (bus.rd === 1'b1) begin
                    @(posedge clk); #1;
                end
                repeat (hold) @(posedge clk);
                #1;
                bus.d_ready  = 1'b0;
                last_dr_fall = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd_high(input string tag);
        bit got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.rd === 1'b1) got = 1;
        end
        check(tag, 32'(got), 32'd1);
        last_rd_rise = cyc;
    endtask

    // One read: expects the field of word and the reference block average.
    task automatic do_read(input logic [15:0] word, input bit chk_lat, input int en_drop);
        bit got = 0;
        bit rd_drop = 0;
        int exp_f;
        int sum;
        next_word = word;
        wait_rd_high("rd_request");
        if (en_drop > 0) begin
            repeat (en_drop) @(posedge clk);
            #1 en = 1'b0;
        end
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) got = 1;
            else if (bus.rd !== 1'b1) rd_drop = 1;
        end
        check("sample_valid_seen", 32'(got), 32'd1);
        if (got) begin
            check("rd_continuous", 32'(rd_drop), 32'd0);
            check("rd_low_at_capture", 32'(bus.rd), 32'd0);
            if (chk_lat) check("capture_latency", 32'(cyc - last_rd_rise), 32'd23);
            exp_f = (int'(word) / (1 << FL)) % (1 << FW);
            check("sample", 32'(sample), 32'(exp_f));
            blk.push_back(exp_f);
            check("avg_valid", 32'(avg_valid), 32'(blk.size() == N));
            if (blk.size() == N) begin
                sum = 0;
                foreach (blk[k]) sum += blk[k];
                check("avg", 32'(avg), 32'(sum / N));
                blk.delete();
            end
            @(negedge clk);
            check("sample_valid_pulse", 32'(sample_valid), 32'd0);
            check("avg_valid_pulse", 32'(avg_valid), 32'd0);
        end
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (busy === 1'b0) got = 1;
        end
        check("idle_reached", 32'(got), 32'd1);
    endtask

    initial begin
        bit got;
        bit seen;
        int te_cyc;
        int en_edge;
        int guard;

        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd", 32'(bus.rd), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_avg", 32'(avg), 32'd0);
        check("rst_avg_valid", 32'(avg_valid), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        rel = cyc;

        // Single read.
        do_read(16'h0AB0, 1'b1, 0);
        check("first_req_delay", 32'(last_rd_rise - rel), 32'(SP));
        check("first_sample_ab", 32'(sample), 32'h0000_00AB);
        wait_idle();
        check("busy_idle", 32'(busy), 32'd0);

        // Fresh block of four fixed fields.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        blk.delete();
        do_read(16'h0100, 1'b1, 0);
        do_read(16'h0200, 1'b1, 0);
        check("req_spacing", 32'(last_rd_rise - last_dr_fall), 32'(3 + SP));
        do_read(16'h0300, 1'b1, 0);
        do_read(16'h0410, 1'b1, 0);
        check("fixed_block_avg", 32'(avg), 32'h0000_0028);

        // Random words.
        for (int i = 0; i < 8; i++) begin
            do_read(16'($urandom), 1'b1, 0);
            check("rand_spacing", 32'(last_rd_rise - last_dr_fall), 32'(3 + SP));
        end

        // Reader never answers: timeout, then retry after the period.
        mode = M_NEVER;
        wait_rd_high("to_rd_request");
        got  = 0;
        seen = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) seen = 1;
            if (timeout_err === 1'b1) got = 1;
        end
        te_cyc = cyc;
        check("timeout_seen", 32'(got), 32'd1);
        check("timeout_delay", 32'(te_cyc - last_rd_rise), 32'(TO));
        check("timeout_rd_low", 32'(bus.rd), 32'd0);
        check("timeout_no_sample", 32'(seen), 32'd0);
        @(negedge clk);
        check("timeout_pulse", 32'(timeout_err), 32'd0);
        mode = M_NORMAL;
        do_read(16'($urandom), 1'b1, 0);
        check("retry_delay", 32'(last_rd_rise - te_cyc), 32'(1 + SP));

        // d_ready held long after rd falls.
        mode = M_HOLD;
        do_read(16'($urandom), 1'b1, 0);
        mode = M_NORMAL;
        do_read(16'($urandom), 1'b1, 0);
        check("hold_spacing", 32'(last_rd_rise - last_dr_fall), 32'(3 + SP));

        // en dropped mid-transaction.
        do_read(16'($urandom), 1'b1, 5);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rd === 1'b1) seen = 1;
        end
        check("en_low_no_rd", 32'(seen), 32'd0);
        check("en_low_idle", 32'(busy), 32'd0);
        @(posedge clk); #1 en = 1'b1;
        en_edge = cyc;
        do_read(16'($urandom), 1'b1, 0);
        check("en_resume_delay", 32'(last_rd_rise - en_edge), 32'(SP));

        // Reset while in REQ with a partially filled block.
        guard = 0;
        while (blk.size() != 2 && guard < 8) begin
            do_read(16'($urandom), 1'b1, 0);
            guard++;
        end
        check("block_fill", 32'(blk.size()), 32'd2);
        wait_rd_high("pre_rst_rd");
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        blk.delete();
        @(negedge clk);
        check("mid_rst_rd", 32'(bus.rd), 32'd0);
        check("mid_rst_avg", 32'(avg), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        do_read(16'($urandom), 1'b0, 0);
        for (int i = 0; i < 3; i++) do_read(16'($urandom), 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
